polar_decoder_output_packer: RTL and testbench
==============================================

# polar_decoder_output_packer

Downstream stage of the polar decoder controller FSM. It collects the hard-decision bits produced one at a time during successive cancellation and discards frozen positions. The information bits are packed into DATA_WIDTH-bit words, buffered, and streamed as one AXI-Stream master packet per frame. The block generates the maxi_tvalid and maxi_tlast that the controller uses to leave its output-wait and output states.

## Interface
Parameters:
- N, 1024, code length; power of two, ≥ 2.
- K, 512, information bits per frame; 1 ≤ K ≤ N.
- DATA_WIDTH, 32, output word width.
- Derived: W = ceil(K/DATA_WIDTH) output words; BIT_CNT_W = $clog2(N).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- bit_valid  in  1  one decoded bit presented this cycle.
- bit_value  in  1  decoded bit û_i.
- bit_frozen  in  1  position i is frozen.
- output_en  in  1  controller permits output (high in output-wait and output states).
- maxi_tdata  out  DATA_WIDTH  packed information bits.
- maxi_tvalid  out  1  AXI-Stream valid.
- maxi_tready  in  1  AXI-Stream ready.
- maxi_tlast  out  1  high on word W-1.
- frame_ready  out  1  frame fully buffered, awaiting output.
- count_err  out  1  one-cycle pulse: frame ended with info count ≠ K.
- overrun_err  out  1  one-cycle pulse: bit_valid outside COLLECT.
- frozen_err  out  1  one-cycle pulse: frozen bit decoded as 1 (see Configuration).

## Operation
- States: COLLECT, HOLD, SEND. Reset state is COLLECT.
- COLLECT:
  - Each bit_valid increments bit_cnt.
  - A non-frozen bit is written to shift_word[info_cnt % DATA_WIDTH], LSB-first, and info_cnt increments. Frozen bits are dropped.
  - When a bit fills shift_word bit DATA_WIDTH-1, the word is written to buffer[wr_ptr], wr_ptr increments, and shift_word clears.
  - On the bit_valid with bit_cnt == N-1:
    - Any partial word is flushed to the buffer, zero-padded in the MSBs.
    - The state moves to HOLD.
    - count_err pulses if the final info_cnt ≠ K.
  - info bits beyond K are dropped; no buffer write past W-1.
- HOLD: frame_ready = 1. When output_en is sampled high, move to SEND with rd_ptr = 0.
- SEND:
  - maxi_tvalid = 1 and maxi_tdata = buffer[rd_ptr].
  - On maxi_tvalid & maxi_tready, rd_ptr increments.
  - The handshake with rd_ptr == W-1 returns the state to COLLECT and clears bit_cnt, info_cnt, wr_ptr and shift_word.
- A bit_valid in HOLD or SEND is ignored and overrun_err pulses.
- output_en is not re-checked in SEND: once started, a packet always completes.
- Buffer words never written in a short frame (count_err case) hold their previous value. Downstream treats the packet as corrupt.

## Timing
- Reset values: maxi_tdata 0, maxi_tvalid 0, maxi_tlast 0, frame_ready 0, all error pulses 0; all counters and pointers 0.
- A bit accepted in cycle t is visible in the buffer by cycle t+1.
- The last bit_valid at t gives frame_ready high at t+1.
- output_en sampled high at t gives maxi_tvalid high at t+1.
- maxi_tdata, maxi_tvalid and maxi_tlast are registered and hold stable while tvalid & !tready.
- Throughput is one word per cycle with tready held high. W-word packet occupies W cycles.
- maxi_tvalid drops the cycle after the last handshake. frame_ready is low in SEND.
- A reset mid-frame or mid-packet discards everything and tvalid drops immediately. There is no partial-packet recovery.

## Configuration
- POLAR_OUT_FROZEN_CHECK_EN defined: a bit_valid with bit_frozen = 1 and bit_value = 1 in COLLECT pulses frozen_err the next cycle. Data flow is unaffected.
- Undefined: frozen_err is tied to 0 and the comparison logic is absent.

## Structure
- Shared package polar_decoder_pkg:
  - state enum typedef (COLLECT, HOLD, SEND);
  - default N, K, DATA_WIDTH constants;
  - W computation function.
- Sub-module polar_out_word_buffer: W×DATA_WIDTH register array with one synchronous write port and one combinational read port. The top level registers the read data onto maxi_tdata.

## Test plan
- N=8, K=4, DATA_WIDTH=4, frozen mask 11101000 (bit0 first), bits 0,1,0,1,1,0,1,1 → one word maxi_tdata=4'b1101, tlast=1, count_err=0.
- N=1024, K=512, DATA_WIDTH=32, all info bits 1, tready always 1 → 16 words of 32'hFFFFFFFF in 16 consecutive cycles, tlast on the 16th.
- Same frame, tready toggling 1,0,0,1 → data and tlast stable during stalls, exactly 16 handshakes.
- K=4 frame with only 3 non-frozen bits → count_err pulse one cycle after the final bit; packet still 1 word.
- bit_valid asserted in SEND → overrun_err pulse, packet contents unchanged. Reset asserted mid-SEND → tvalid 0 immediately, next frame packs from word 0.
- Macro defined: frozen position decoded 1 → frozen_err pulse. Macro undefined, same stimulus → frozen_err stays 0.

Source files
------------

// File: rtl/polar_decoder_pkg.sv
// Shared types and constants for the polar decoder output path.
package polar_decoder_pkg;

  // Packer states: gather bits, wait for controller permission, stream packet
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam int DEF_N          = 1024;
  localparam int DEF_K          = 512;
  localparam int DEF_DATA_WIDTH = 32;

  // Number of output words needed to carry k information bits
  function automatic int calc_words(input int k, input int dw);
    return (k + dw - 1) / dw;
  endfunction

  // Address width for an index range of 'depth' entries (at least one bit)
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/polar_out_word_buffer.sv
// Frame buffer: W words of DATA_WIDTH bits, one synchronous write port and
// one combinational read port. Contents are not reset; words not rewritten
// by a frame keep their previous value.
module polar_out_word_buffer #(
  parameter int W          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [W];

  // Store a completed (or flushed) word at the write pointer
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Out-of-range addresses (only seen transiently past the last word) read as 0
  assign o_rd_data = ({1'b0, i_rd_addr} < (ADDR_W + 1)'(W)) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/polar_decoder_output_packer.sv
// Polar decoder output packer: drops frozen positions, packs information bits
// LSB-first into DATA_WIDTH-bit words, buffers one frame and streams it as a
// single AXI-Stream packet once the controller raises output_en.
// Optional build macro POLAR_OUT_FROZEN_CHECK_EN enables the frozen_err check
// (frozen position decoded as 1); without it frozen_err is tied low.
module polar_decoder_output_packer
  import polar_decoder_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_valid,
  input  logic                  bit_value,
  input  logic                  bit_frozen,
  input  logic                  output_en,
  output logic [DATA_WIDTH-1:0] maxi_tdata,
  output logic                  maxi_tvalid,
  input  logic                  maxi_tready,
  output logic                  maxi_tlast,
  output logic                  frame_ready,
  output logic                  count_err,
  output logic                  overrun_err,
  output logic                  frozen_err
);

  localparam int W         = calc_words(K, DATA_WIDTH);
  localparam int BIT_CNT_W = $clog2(N);
  localparam int INFO_W    = $clog2(N + 1);
  localparam int PTR_W     = addr_width(W);
  localparam int POS_W     = addr_width(DATA_WIDTH);

  state_t                r_state;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [INFO_W-1:0]     r_info_cnt;
  logic [POS_W-1:0]      r_bit_pos;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_shift_word;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_frame_ready;
  logic                  r_count_err;
  logic                  r_overrun_err;

  logic                  w_collect_bit;
  logic                  w_last_bit;
  logic                  w_take;
  logic                  w_word_full;
  logic                  w_wr_en;
  logic [INFO_W-1:0]     w_info_cnt_next;
  logic [DATA_WIDTH-1:0] w_word_ins;
  logic                  w_handshake;
  logic                  w_last_word;
  logic                  w_packet_done;
  logic [PTR_W-1:0]      w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_collect_bit   = (r_state == COLLECT) && bit_valid;
  assign w_last_bit      = w_collect_bit && (r_bit_cnt == BIT_CNT_W'(N - 1));
  // Information bits past K are counted for the error check but not stored
  assign w_take          = w_collect_bit && !bit_frozen && (r_info_cnt < INFO_W'(K));
  assign w_word_full     = w_take && (r_bit_pos == POS_W'(DATA_WIDTH - 1));
  // Final bit flushes any partially filled word (upper bits are still zero)
  assign w_wr_en         = w_word_full || (w_last_bit && (w_take || (r_bit_pos != '0)));
  assign w_info_cnt_next = r_info_cnt + INFO_W'(w_collect_bit && !bit_frozen);

  // Shift word with the incoming bit inserted at its position, so the bit
  // reaches the buffer in the same cycle it completes or ends the frame
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ins
      assign w_word_ins[gi] = (w_take && (r_bit_pos == POS_W'(gi))) ? bit_value : r_shift_word[gi];
    end
  endgenerate

  assign w_handshake   = r_tvalid && maxi_tready;
  assign w_last_word   = (r_rd_ptr == PTR_W'(W - 1));
  assign w_packet_done = (r_state == SEND) && w_handshake && w_last_word;
  // Prefetch address: word 0 when starting, otherwise the word after the one on the bus
  assign w_rd_addr     = (r_state == HOLD) ? '0 : (r_rd_ptr + PTR_W'(1));

  polar_out_word_buffer #(
    .W          (W),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_word_ins),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Bit/info counters, word assembly and write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_info_cnt   <= '0;
      r_bit_pos    <= '0;
      r_wr_ptr     <= '0;
      r_shift_word <= '0;
    end else if (w_packet_done) begin
      r_bit_cnt    <= '0;
      r_info_cnt   <= '0;
      r_bit_pos    <= '0;
      r_wr_ptr     <= '0;
      r_shift_word <= '0;
    end else if (w_collect_bit) begin
      r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      r_info_cnt <= w_info_cnt_next;
      if (w_wr_en) begin
        r_shift_word <= '0;
        r_bit_pos    <= '0;
        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
      end else if (w_take) begin
        r_shift_word <= w_word_ins;
        r_bit_pos    <= r_bit_pos + POS_W'(1);
      end
    end
  end

  // Frame FSM with registered stream outputs and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= COLLECT;
      r_rd_ptr      <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_frame_ready <= 1'b0;
      r_count_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_count_err   <= 1'b0;
      r_overrun_err <= bit_valid && (r_state != COLLECT);
      case (r_state)
        COLLECT: begin
          if (w_last_bit) begin
            r_state       <= HOLD;
            r_frame_ready <= 1'b1;
            r_count_err   <= (w_info_cnt_next != INFO_W'(K));
          end
        end
        HOLD: begin
          if (output_en) begin
            r_state       <= SEND;
            r_frame_ready <= 1'b0;
            r_rd_ptr      <= '0;
            r_tvalid      <= 1'b1;
            r_tdata       <= w_rd_data;
            r_tlast       <= (W == 1);
          end
        end
        SEND: begin
          if (w_handshake) begin
            if (w_last_word) begin
              r_state  <= COLLECT;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
              r_tdata  <= w_rd_data;
              r_tlast  <= (r_rd_ptr == PTR_W'(W - 2));
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

`ifdef POLAR_OUT_FROZEN_CHECK_EN
  logic r_frozen_err;

  // Flag a frozen position that the decoder resolved to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frozen_err <= 1'b0;
    end else begin
      r_frozen_err <= w_collect_bit && bit_frozen && bit_value;
    end
  end

  assign frozen_err = r_frozen_err;
`else
  assign frozen_err = 1'b0;
`endif

  assign maxi_tdata  = r_tdata;
  assign maxi_tvalid = r_tvalid;
  assign maxi_tlast  = r_tlast;
  assign frame_ready = r_frame_ready;
  assign count_err   = r_count_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_polar_decoder_output_packer.sv
// Scoreboard bench for polar_decoder_output_packer: random frozen masks and
// bit values, expected words built from the packing rules, monitor compares
// every AXI-Stream beat. Honours POLAR_OUT_FROZEN_CHECK_EN for frozen_err.
`timescale 1ns/1ps
module tb_polar_decoder_output_packer;

  localparam int N  = 32;
  localparam int K  = 13;
  localparam int DW = 4;
  localparam int W  = (K + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_valid;
  logic          bit_value;
  logic          bit_frozen;
  logic          output_en;
  logic [DW-1:0] maxi_tdata;
  logic          maxi_tvalid;
  logic          maxi_tready;
  logic          maxi_tlast;
  logic          frame_ready;
  logic          count_err;
  logic          overrun_err;
  logic          frozen_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model_buf [W];
  int            checks = 0;
  int            errors = 0;
  int            tready_mode = 0;

  always #5 clk = ~clk;

  polar_decoder_output_packer #(
    .N          (N),
    .K          (K),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .bit_frozen  (bit_frozen),
    .output_en   (output_en),
    .maxi_tdata  (maxi_tdata),
    .maxi_tvalid (maxi_tvalid),
    .maxi_tready (maxi_tready),
    .maxi_tlast  (maxi_tlast),
    .frame_ready (frame_ready),
    .count_err   (count_err),
    .overrun_err (overrun_err),
    .frozen_err  (frozen_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic val, input logic frz, input logic in_collect);
    bit_valid  = 1'b1;
    bit_value  = val;
    bit_frozen = frz;
    tick();
    bit_valid  = 1'b0;
    bit_value  = 1'b0;
    bit_frozen = 1'b0;
`ifdef POLAR_OUT_FROZEN_CHECK_EN
    check("frozen_err", frozen_err, in_collect && frz && val);
`else
    check("frozen_err", frozen_err, 0);
`endif
  endtask

  // One frame: n_info non-frozen positions, optional overrun and mid-packet reset
  task automatic run_frame(input int n_info, input bit overrun, input bit reset_mid);
    bit            frz [N];
    bit            val [N];
    bit            info[$];
    int            cnt;
    int            p;
    int            used;
    int            nwr;
    int            budget;
    logic [DW-1:0] w;
    for (int i = 0; i < N; i++) begin
      frz[i] = 1'b1;
      val[i] = 1'($urandom_range(0, 1));
    end
    cnt = 0;
    while (cnt < n_info) begin
      p = $urandom_range(0, N - 1);
      if (frz[p]) begin
        frz[p] = 1'b0;
        cnt++;
      end
    end
    for (int i = 0; i < N; i++) if (!frz[i]) info.push_back(val[i]);
    used = (info.size() < K) ? info.size() : K;
    nwr  = (used + DW - 1) / DW;
    for (int wi = 0; wi < nwr; wi++) begin
      w = '0;
      for (int j = 0; j < DW; j++) if (wi * DW + j < used) w[j] = info[wi * DW + j];
      model_buf[wi] = w;
    end
    for (int wi = 0; wi < W; wi++) exp_q.push_back('{data: model_buf[wi], last: (wi == W - 1)});
    $display("frame: info=%0d overrun=%0d reset_mid=%0d tready_mode=%0d", n_info, overrun, reset_mid, tready_mode);

    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if (i == N - 1) check("frame_ready_before_last", frame_ready, 0);
      drive_bit(val[i], frz[i], 1'b1);
    end
    check("frame_ready", frame_ready, 1);
    check("count_err", count_err, n_info != K);
    tick();
    check("count_err_one_cycle", count_err, 0);

    repeat ($urandom_range(0, 2)) begin
      tick();
      check("hold_tvalid", maxi_tvalid, 0);
    end
    check("hold_frame_ready", frame_ready, 1);
    if (overrun) begin
      drive_bit(1'b1, 1'b0, 1'b0);
      check("overrun_hold", overrun_err, 1);
    end
    output_en = 1'b1;
    tick();
    output_en = 1'b0;
    check("send_tvalid", maxi_tvalid, 1);
    check("send_frame_ready", frame_ready, 0);
    if (overrun) begin
      drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("overrun_send", overrun_err, 1);
    end

    if (reset_mid) begin
      tick();
      reset = 1'b1;
      #1;
      check("reset_tvalid", maxi_tvalid, 0);
      check("reset_frame_ready", frame_ready, 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
    end else begin
      budget = 0;
      while (maxi_tvalid && budget < 200) begin
        tick();
        budget++;
      end
      check("packet_done", maxi_tvalid, 0);
      check("beats_left", exp_q.size(), 0);
    end
  endtask

  // Ready driver: always high, 1,0,0,1 pattern, or random
  initial begin : ready_drv
    int idx;
    idx = 0;
    maxi_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: maxi_tready = 1'b1;
        1: begin
          maxi_tready = ((idx % 4) == 0) || ((idx % 4) == 3);
          idx++;
        end
        default: maxi_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops expected beats on handshakes and checks stall stability
  initial begin : monitor
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         b;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", maxi_tvalid, 1);
          check("stall_tdata", maxi_tdata, prev_data);
          check("stall_tlast", maxi_tlast, prev_last);
        end
        if (maxi_tvalid && maxi_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tdata %0h with no beat expected at %0t", maxi_tdata, $time);
          end else begin
            b = exp_q.pop_front();
            check("beat_tdata", maxi_tdata, b.data);
            check("beat_tlast", maxi_tlast, b.last);
            $display("beat: tdata=%0h tlast=%0b", maxi_tdata, maxi_tlast);
          end
        end
        prev_stall = maxi_tvalid && !maxi_tready;
        prev_data  = maxi_tdata;
        prev_last  = maxi_tlast;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset      = 1'b1;
    bit_valid  = 1'b0;
    bit_value  = 1'b0;
    bit_frozen = 1'b0;
    output_en  = 1'b0;
    repeat (3) tick();
    check("rst_tdata", maxi_tdata, 0);
    check("rst_tvalid", maxi_tvalid, 0);
    check("rst_tlast", maxi_tlast, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_count_err", count_err, 0);
    check("rst_overrun_err", overrun_err, 0);
    check("rst_frozen_err", frozen_err, 0);
    reset = 1'b0;
    tick();

    tready_mode = 0;
    repeat (3) run_frame(K, 1'b0, 1'b0);
    run_frame(N, 1'b0, 1'b0);
    run_frame(K - 3, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(K, 1'b0, 1'b0);

    tready_mode = 1;
    run_frame(K, 1'b1, 1'b0);
    run_frame(K, 1'b0, 1'b0);

    tready_mode = 2;
    run_frame(K, 1'b0, 1'b0);
    run_frame(K, 1'b1, 1'b1);
    run_frame(K, 1'b0, 1'b0);
    repeat (4) run_frame($urandom_range(K - 2, K + 2), 1'($urandom_range(0, 1)), 1'b0);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
